// File: rtl/uart_tx_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_param : parametrised UART transmitter with valid/ready word input.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry pending FIFO (else one register).
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [11:0] TIMER_LAST = 12'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic        PAR_EN     = (PARITY != 0);
  localparam logic        PAR_ODD    = (PARITY == 2);
  localparam bit          CFG_OK     = (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                                       (CLKS_PER_BIT >= 2) && (CLKS_PER_BIT <= 4096) &&
                                       (PARITY >= 0) && (PARITY <= 2) &&
                                       (STOP_BITS >= 1) && (STOP_BITS <= 2) &&
                                       (FIFO_DEPTH >= 2) &&
                                       ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  if (!CFG_OK) begin : g_bad_config
    $error("uart_tx_param: illegal parameter combination");
  end

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [11:0]          timer;
  logic [3:0]           bit_cnt;
  logic                 tick;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 tx_next;
  logic                 frame_end;
  logic                 push;
  logic                 pop;
  logic                 pending;
  logic [DATA_BITS-1:0] pend_word;

  assign push = wr_valid && wr_ready;
  assign tick = (timer == TIMER_LAST);

`ifdef UART_TX_FIFO_EN
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pending   = (count != '0);
  assign pend_word = mem[rd_ptr];
  assign wr_ready  = (count < DEPTH_C);
`else
  logic [DATA_BITS-1:0] hold;
  logic                 hold_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
    end else if (push) begin
      hold       <= data_in;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign pending   = hold_valid;
  assign pend_word = hold;
  assign wr_ready  = !busy;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (pending) next_state = S_START;
      S_START:  if (tick) next_state = S_DATA;
      S_DATA:   if (tick && (bit_cnt == DATA_LAST)) next_state = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (tick) next_state = S_STOP;
      S_STOP:   if (tick && (bit_cnt == STOP_LAST)) next_state = pending ? S_START : S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    tx_next   = 1'b1;
    frame_end = 1'b0;
    busy      = (state != S_IDLE) || pending;
    case (state)
      S_IDLE:   pop = pending;
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift[0];
      S_PARITY: tx_next = par_bit;
      S_STOP: begin
        frame_end = tick && (bit_cnt == STOP_LAST);
        pop       = frame_end && pending;
      end
      default: ;
    endcase
  end

  // tx is one cycle behind the state, which yields the two-cycle start latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      tx         <= tx_next;
      frame_done <= frame_end;
      if ((state == S_IDLE) || tick) begin
        timer <= '0;
      end else begin
        timer <= timer + 12'd1;
      end
      if (next_state != state) begin
        bit_cnt <= '0;
      end else if (tick) begin
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (pop) begin
        shift   <= pend_word;
        par_bit <= (^pend_word) ^ PAR_ODD;
      end else if ((state == S_DATA) && tick) begin
        shift <= shift >> 1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// tb_uart_tx_param: table-driven bench over three uart_tx_param configurations.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din0;
  logic [6:0] din1;
  logic [4:0] din2;
  logic       valid0, valid1, valid2;
  logic       ready0, ready1, ready2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       fd0, fd1, fd2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          unit;
    logic [7:0]  word;
    logic [12:0] frame;
    int          len;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8e1 (
    .clk(clk), .reset(reset), .data_in(din0), .wr_valid(valid0), .wr_ready(ready0),
    .tx(tx0), .busy(busy0), .frame_done(fd0));

  uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_7o2 (
    .clk(clk), .reset(reset), .data_in(din1), .wr_valid(valid1), .wr_ready(ready1),
    .tx(tx1), .busy(busy1), .frame_done(fd1));

  uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(3), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(2)) dut_5n1 (
    .clk(clk), .reset(reset), .data_in(din2), .wr_valid(valid2), .wr_ready(ready2),
    .tx(tx2), .busy(busy2), .frame_done(fd2));

  function automatic int cpb_of(input int u);
    case (u)
      0:       return 16;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic get_tx(input int u);
    case (u)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic get_busy(input int u);
    case (u)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic get_fd(input int u);
    case (u)
      0:       return fd0;
      1:       return fd1;
      default: return fd2;
    endcase
  endfunction

  function automatic logic get_ready(input int u);
    case (u)
      0:       return ready0;
      1:       return ready1;
      default: return ready2;
    endcase
  endfunction

  task automatic drive(input int u, input logic v, input logic [7:0] w);
    case (u)
      0:       begin valid0 = v; din0 = w;      end
      1:       begin valid1 = v; din1 = w[6:0]; end
      default: begin valid2 = v; din2 = w[4:0]; end
    endcase
  endtask

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge of the last tx cycle.
  task automatic run_frame(input int u, input logic [7:0] w, input logic [12:0] fr,
                           input int len, input bit inj, input string tag);
    int   cpb;
    int   total;
    int   bad_tx;
    int   bad_fd;
    int   bad_busy;
    int   bad_rdy;
    logic exp_rdy;
    cpb      = cpb_of(u);
    total    = len * cpb;
    bad_tx   = 0;
    bad_fd   = 0;
    bad_busy = 0;
    bad_rdy  = 0;
    chk(get_ready(u) === 1'b1, {tag, "_ready_before"}, int'(get_ready(u)), 1);
    drive(u, 1'b1, w);
    @(posedge clk);
    @(negedge clk);
    drive(u, 1'b0, ~w);
    chk(get_tx(u) === 1'b1 && get_busy(u) === 1'b1, {tag, "_pop_cycle_tx_busy"},
        int'({get_tx(u), get_busy(u)}), 3);
    @(negedge clk);
    drive(u, 1'b0, 8'($urandom()));
    chk(get_tx(u) === 1'b1, {tag, "_tx_before_start"}, int'(get_tx(u)), 1);
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (inj && k >= 10 && k < 30) drive(u, 1'b1, 8'h0F);
      else                          drive(u, 1'b0, 8'($urandom()));
      if (get_tx(u) !== fr[k / cpb])              bad_tx++;
      if (get_fd(u) !== (k == total - 1))         bad_fd++;
      if (get_busy(u) !== (k != total - 1))       bad_busy++;
`ifdef UART_TX_FIFO_EN
      exp_rdy = 1'b1;
`else
      exp_rdy = (k == total - 1);
`endif
      if (get_ready(u) !== exp_rdy)               bad_rdy++;
    end
    drive(u, 1'b0, 8'h00);
    chk(bad_tx == 0,   {tag, "_tx_cycles_wrong"},         bad_tx,   0);
    chk(bad_fd == 0,   {tag, "_frame_done_cycles_wrong"}, bad_fd,   0);
    chk(bad_busy == 0, {tag, "_busy_cycles_wrong"},       bad_busy, 0);
    chk(bad_rdy == 0,  {tag, "_ready_cycles_wrong"},      bad_rdy,  0);
  endtask

  task automatic idle_check(input int u, input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (get_tx(u) !== 1'b1 || get_busy(u) !== 1'b0 || get_fd(u) !== 1'b0) bad++;
    end
    chk(bad == 0, tag, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] sf [6];
    int          nw;
    int          bad_tx;
    int          bad_fd;
    int          bad_busy;
    int          k;

    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);

    // {unit, word, {stop(s), parity, data, start}, bits per frame}
    vecs[0] = '{0, 8'hA5, 13'({1'b1, 1'b0, 8'hA5, 1'b0}), 11};
    vecs[1] = '{0, 8'h3C, 13'({1'b1, 1'b0, 8'h3C, 1'b0}), 11};
    vecs[2] = '{0, 8'h01, 13'({1'b1, 1'b1, 8'h01, 1'b0}), 11};
    vecs[3] = '{0, 8'h80, 13'({1'b1, 1'b1, 8'h80, 1'b0}), 11};
    vecs[4] = '{1, 8'h7F, 13'({2'b11, 1'b0, 7'h7F, 1'b0}), 11};
    vecs[5] = '{1, 8'h00, 13'({2'b11, 1'b1, 7'h00, 1'b0}), 11};
    vecs[6] = '{1, 8'h15, 13'({2'b11, 1'b0, 7'h15, 1'b0}), 11};
    vecs[7] = '{1, 8'h55, 13'({2'b11, 1'b1, 7'h55, 1'b0}), 11};
    vecs[8] = '{2, 8'h1B, 13'({1'b1, 5'h1B, 1'b0}), 7};
    vecs[9] = '{2, 8'h0A, 13'({1'b1, 5'h0A, 1'b0}), 7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++)
      chk(get_tx(u) === 1'b1 && get_busy(u) === 1'b0 && get_fd(u) === 1'b0, "reset_state",
          int'({get_tx(u), get_busy(u), get_fd(u)}), 4);
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++)
      chk(get_ready(u) === 1'b1 && get_tx(u) === 1'b1, "ready_after_reset",
          int'({get_ready(u), get_tx(u)}), 3);

    for (int i = 0; i < 10; i++)
      run_frame(vecs[i].unit, vecs[i].word, vecs[i].frame, vecs[i].len, 1'b0,
                $sformatf("vec%0d", i));
    idle_check(0, 5, "idle_after_vectors");

`ifdef UART_TX_FIFO_EN
    sf[0] = {1'b1, 1'b1, 8'h01, 1'b0};
    sf[1] = {1'b1, 1'b1, 8'h02, 1'b0};
    sf[2] = {1'b1, 1'b0, 8'h03, 1'b0};
    sf[3] = {1'b1, 1'b1, 8'h04, 1'b0};
    sf[4] = {1'b1, 1'b0, 8'h05, 1'b0};
    sf[5] = {1'b1, 1'b0, 8'h06, 1'b0};
    bad_tx   = 0;
    bad_fd   = 0;
    bad_busy = 0;
    drive(0, 1'b1, 8'h01);
    @(posedge clk);
    nw = 2;
    for (int t = 0; t <= 2 + 6 * 176; t++) begin
      @(negedge clk);
      if (t == 4) begin
        chk(nw == 6, "stream_accepts_before_full", nw - 1, 5);
        chk(get_ready(0) === 1'b0, "stream_ready_when_full", int'(get_ready(0)), 0);
      end
      if (t >= 2 && t < 2 + 6 * 176) begin
        k = t - 2;
        if (get_tx(0) !== sf[k / 176][(k % 176) / 16]) bad_tx++;
        if (get_fd(0) !== ((k % 176) == 175))          bad_fd++;
        if (get_busy(0) !== (k != 6 * 176 - 1))        bad_busy++;
      end
      if (nw <= 6) begin
        drive(0, 1'b1, 8'(nw));
        if (get_ready(0) === 1'b1) nw++;
      end else begin
        drive(0, 1'b0, 8'($urandom()));
      end
    end
    drive(0, 1'b0, 8'h00);
    chk(nw == 7,       "stream_all_accepted", nw - 1, 6);
    chk(bad_tx == 0,   "stream_tx_cycles_wrong", bad_tx, 0);
    chk(bad_fd == 0,   "stream_frame_done_cycles_wrong", bad_fd, 0);
    chk(bad_busy == 0, "stream_busy_cycles_wrong", bad_busy, 0);
    idle_check(0, 20, "stream_idle_after");
`else
    sf[0] = '0;
    nw = 0;
    run_frame(0, 8'h5A, 13'({1'b1, 1'b0, 8'h5A, 1'b0}), 11, 1'b1, "busy_write");
    idle_check(0, 40, "busy_write_ignored");
`endif

    // Abort 0xFF during data bit 3 with words queued where storage allows.
    drive(0, 1'b1, 8'hFF);
    @(posedge clk);
    for (int t = 0; t < 72; t++) begin
      @(negedge clk);
`ifdef UART_TX_FIFO_EN
      if (t == 0)      drive(0, 1'b1, 8'h11);
      else if (t == 1) drive(0, 1'b1, 8'h22);
      else             drive(0, 1'b0, 8'h00);
`else
      drive(0, 1'b0, 8'h00);
`endif
    end
    chk(get_tx(0) === 1'b1 && get_busy(0) === 1'b1, "abort_in_frame",
        int'({get_tx(0), get_busy(0)}), 3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(get_tx(0) === 1'b1 && get_busy(0) === 1'b0 && get_fd(0) === 1'b0, "abort_reset_state",
        int'({get_tx(0), get_busy(0), get_fd(0)}), 4);
    reset = 1'b0;
    @(negedge clk);
    chk(get_ready(0) === 1'b1, "abort_ready_after_release", int'(get_ready(0)), 1);
    idle_check(0, 400, "abort_no_resume");
    run_frame(0, 8'h55, 13'({1'b1, 1'b0, 8'h55, 1'b0}), 11, 1'b0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
